// File: rtl/vga_driver.sv
// VGA timing generator with a 2-clock pixel pipeline from coordinate request to DAC output.
// Optional colour-bar test pattern is enabled by defining VGA_TEST_PATTERN_EN.
module vga_driver #(
   parameter int H_DISP  = 640,
   parameter int H_FRONT = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BACK  = 48,
   parameter int V_DISP  = 480,
   parameter int V_FRONT = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BACK  = 33
) (
   input  logic        clk_VGA,
   input  logic        rst_n,
   input  logic [11:0] VGA_data,
   input  logic        pattern_sel,
   output logic [10:0] VGA_xpos,
   output logic [10:0] VGA_ypos,
   output logic        VGA_hsync,
   output logic        VGA_vsync,
   output logic [11:0] VGA_rgb,
   output logic        VGA_de,
   output logic        frame_start
);

   localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_DISP_W = 11'(H_DISP);
   localparam logic [10:0] V_DISP_W = 11'(V_DISP);
   localparam logic [10:0] HS_START = 11'(H_DISP + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_DISP + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_DISP + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_DISP + V_FRONT + V_SYNC);

   logic        started_q, started_d;
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic [10:0] xpos_q, xpos_d;
   logic [10:0] ypos_q, ypos_d;
   logic        win0_q, win0_d;
   logic        hs0_q, hs0_d;
   logic        vs0_q, vs0_d;
   logic        win1_q, win1_d;
   logic        hs1_q, hs1_d;
   logic        vs1_q, vs1_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        de_q, de_d;
   logic [11:0] rgb_q, rgb_d;
   logic        fs_q, fs_d;
   logic        h_wrap_s;
   logic [11:0] pix_s;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [10:0] BAR_W = 11'(H_DISP / 8);

   logic [10:0] x1_q;
   logic [10:0] bar_idx_s;
   logic [11:0] bar_rgb_s;

   // Stage-1 column, aligned with the client's registered pixel
   always_ff @(posedge clk_VGA or negedge rst_n) begin
      if (!rst_n) begin
         x1_q <= 11'd0;
      end else begin
         x1_q <= xpos_q;
      end
   end

   // Colour-bar lookup from the stage-1 column
   always_comb begin
      bar_idx_s = x1_q / BAR_W;
      case (bar_idx_s)
         11'd0:   bar_rgb_s = 12'hFFF;
         11'd1:   bar_rgb_s = 12'hFF0;
         11'd2:   bar_rgb_s = 12'h0FF;
         11'd3:   bar_rgb_s = 12'h0F0;
         11'd4:   bar_rgb_s = 12'hF0F;
         11'd5:   bar_rgb_s = 12'hF00;
         11'd6:   bar_rgb_s = 12'h00F;
         default: bar_rgb_s = 12'h000;
      endcase
   end

   assign pix_s = pattern_sel ? bar_rgb_s : VGA_data;
`else
   logic unused_pattern_sel_s;
   assign unused_pattern_sel_s = pattern_sel;
   assign pix_s = VGA_data;
`endif

   // Next-state: counters, request coordinates and the 2-stage sync/window pipeline
   always_comb begin
      started_d = 1'b1;
      h_cnt_d   = 11'd0;
      v_cnt_d   = 11'd0;
      h_wrap_s  = (h_cnt_q == H_LAST);
      // The first clock after reset presents (0,0) rather than advancing
      if (started_q) begin
         h_cnt_d = h_wrap_s ? 11'd0 : h_cnt_q + 11'd1;
         if (h_wrap_s) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
         end else begin
            v_cnt_d = v_cnt_q;
         end
      end else begin
         h_cnt_d = 11'd0;
         v_cnt_d = 11'd0;
      end
      win0_d  = (h_cnt_d < H_DISP_W) && (v_cnt_d < V_DISP_W);
      xpos_d  = win0_d ? h_cnt_d : 11'd0;
      ypos_d  = win0_d ? v_cnt_d : 11'd0;
      hs0_d   = !((h_cnt_d >= HS_START) && (h_cnt_d < HS_END));
      vs0_d   = !((v_cnt_d >= VS_START) && (v_cnt_d < VS_END));
      fs_d    = (h_cnt_d == 11'd0) && (v_cnt_d == 11'd0);
      win1_d  = win0_q;
      hs1_d   = hs0_q;
      vs1_d   = vs0_q;
      hsync_d = hs1_q;
      vsync_d = vs1_q;
      de_d    = win1_q;
      rgb_d   = win1_q ? pix_s : 12'h000;
   end

   // State and output registers
   always_ff @(posedge clk_VGA or negedge rst_n) begin
      if (!rst_n) begin
         started_q <= 1'b0;
         h_cnt_q   <= 11'd0;
         v_cnt_q   <= 11'd0;
         xpos_q    <= 11'd0;
         ypos_q    <= 11'd0;
         win0_q    <= 1'b0;
         hs0_q     <= 1'b1;
         vs0_q     <= 1'b1;
         win1_q    <= 1'b0;
         hs1_q     <= 1'b1;
         vs1_q     <= 1'b1;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         de_q      <= 1'b0;
         rgb_q     <= 12'h000;
         fs_q      <= 1'b0;
      end else begin
         started_q <= started_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         xpos_q    <= xpos_d;
         ypos_q    <= ypos_d;
         win0_q    <= win0_d;
         hs0_q     <= hs0_d;
         vs0_q     <= vs0_d;
         win1_q    <= win1_d;
         hs1_q     <= hs1_d;
         vs1_q     <= vs1_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         de_q      <= de_d;
         rgb_q     <= rgb_d;
         fs_q      <= fs_d;
      end
   end

   assign VGA_xpos    = xpos_q;
   assign VGA_ypos    = ypos_q;
   assign VGA_hsync   = hsync_q;
   assign VGA_vsync   = vsync_q;
   assign VGA_de      = de_q;
   assign VGA_rgb     = rgb_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_driver.sv
// Randomised scoreboard bench for vga_driver on a reduced timing so several frames fit the run.
// Reference timing is derived from the cycle index since reset release with plain arithmetic.
module tb_vga_driver;

   localparam int HD = 32, HF = 4, HS = 6, HB = 6;
   localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        clk_VGA = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] VGA_data = 12'h000;
   logic        pattern_sel = 1'b0;
   logic [10:0] VGA_xpos, VGA_ypos;
   logic        VGA_hsync, VGA_vsync, VGA_de, frame_start;
   logic [11:0] VGA_rgb;

   int          tests = 0;
   int          fails = 0;
   int          ncyc = -1;
   int          last_fs = -1;
   logic [11:0] exp_q[$];
   logic [10:0] px = 11'd0;
   logic [10:0] py = 11'd0;

   vga_driver #(
      .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk_VGA(clk_VGA), .rst_n(rst_n), .VGA_data(VGA_data), .pattern_sel(pattern_sel),
      .VGA_xpos(VGA_xpos), .VGA_ypos(VGA_ypos), .VGA_hsync(VGA_hsync), .VGA_vsync(VGA_vsync),
      .VGA_rgb(VGA_rgb), .VGA_de(VGA_de), .frame_start(frame_start)
   );

   always #5 clk_VGA = ~clk_VGA;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, ncyc, act, exp);
      end
   endtask

   function automatic int mh(int k); return k % HT; endfunction
   function automatic int mv(int k); return (k / HT) % VT; endfunction
   function automatic bit mwin(int k);
      return (k >= 0) && (mh(k) < HD) && (mv(k) < VD);
   endfunction
   function automatic bit mhs(int k);
      if (k < 0) return 1'b1;
      return !((mh(k) >= HD + HF) && (mh(k) < HD + HF + HS));
   endfunction
   function automatic bit mvs(int k);
      if (k < 0) return 1'b1;
      return !((mv(k) >= VD + VF) && (mv(k) < VD + VF + VS));
   endfunction
   function automatic logic [11:0] bar_colour(int x);
      logic [11:0] tbl [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};
      return tbl[x / (HD / 8)];
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_xpos"},  32'(VGA_xpos),    32'd0);
      check({tag, "_ypos"},  32'(VGA_ypos),    32'd0);
      check({tag, "_hsync"}, 32'(VGA_hsync),   32'd1);
      check({tag, "_vsync"}, 32'(VGA_vsync),   32'd1);
      check({tag, "_rgb"},   32'(VGA_rgb),     32'd0);
      check({tag, "_de"},    32'(VGA_de),      32'd0);
      check({tag, "_fs"},    32'(frame_start), 32'd0);
   endtask

   // Client + stimulus: registers the requested pixel and pushes the expected DAC value
   initial begin
      logic [3:0]  r;
      logic        sel;
      logic [10:0] mx, my;
      logic [11:0] e;
      forever begin
         @(posedge clk_VGA);
         if (rst_n) begin
            ncyc++;
            #1;
            r   = 4'($urandom_range(0, 15));
            sel = 1'($urandom_range(0, 1));
            pattern_sel = sel;
            VGA_data    = {px[3:0], py[3:0], r};
            if (mwin(ncyc - 1)) begin
               mx = 11'(mh(ncyc - 1));
               my = 11'(mv(ncyc - 1));
               e  = {mx[3:0], my[3:0], r};
`ifdef VGA_TEST_PATTERN_EN
               if (sel) e = bar_colour(int'(mx));
`endif
               exp_q.push_back(e);
            end
         end
         @(negedge clk_VGA);
         px = VGA_xpos;
         py = VGA_ypos;
      end
   end

   // Monitor: compares timing outputs every cycle and pops the scoreboard on display-enable
   initial begin
      int k;
      logic [11:0] e;
      forever begin
         @(negedge clk_VGA);
         if (rst_n && ncyc >= 0) begin
            k = ncyc;
            check("xpos",  32'(VGA_xpos),  mwin(k) ? 32'(mh(k)) : 32'd0);
            check("ypos",  32'(VGA_ypos),  mwin(k) ? 32'(mv(k)) : 32'd0);
            check("frame_start", 32'(frame_start), 32'((mh(k) == 0) && (mv(k) == 0)));
            check("hsync", 32'(VGA_hsync), 32'(mhs(k - 2)));
            check("vsync", 32'(VGA_vsync), 32'(mvs(k - 2)));
            check("de",    32'(VGA_de),    32'(mwin(k - 2)));
            if (VGA_de === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("rgb_queue_empty", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("rgb", 32'(VGA_rgb), 32'(e));
               end
            end else begin
               check("rgb_blank", 32'(VGA_rgb), 32'd0);
            end
            if (frame_start === 1'b1) begin
               if (last_fs >= 0) check("frame_period", 32'(k - last_fs), 32'(FT));
               last_fs = k;
            end
         end
      end
   end

   initial begin
      int guard;
      rst_n = 1'b0;
      repeat (3) @(posedge clk_VGA);
      #2;
      check_reset_values("por");
      @(negedge clk_VGA);
      #2 rst_n = 1'b1;

      // Run into the second frame, then hit reset mid-line inside the active window
      guard = 0;
      do begin
         @(negedge clk_VGA);
         guard++;
      end while (ncyc != FT + 5 * HT + 20 && guard < 5000);
      if (guard >= 5000) check("reach_reset_point_timeout", 32'd1, 32'd0);
      #2;
      rst_n   = 1'b0;
      ncyc    = -1;
      last_fs = -1;
      exp_q.delete();
      #1;
      check_reset_values("async_rst");
      repeat (2) @(posedge clk_VGA);
      #1;
      check_reset_values("held_rst");
      @(negedge clk_VGA);
      #2 rst_n = 1'b1;

      repeat (2 * FT + 10) @(posedge clk_VGA);
      @(negedge clk_VGA);
      check("scoreboard_drain", 32'(exp_q.size() <= 2), 32'd1);
      check("frames_seen", 32'(last_fs >= FT), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
